// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit
// Description : Fetch stage feeding decode_instruction. Owns the program
//               counter, issues word reads to instruction memory over a
//               req/ack handshake, latches the returned word into an
//               instruction register and presents it to the decoder over a
//               valid/ready handshake. Accepts branch/jump redirects from
//               execute.
//
// Ports:
//   clock          in   system clock, all state on rising edge
//   reset          in   synchronous active-high reset, highest priority
//   mem_req        out  instruction memory read request
//   mem_addr       out  word address of the outstanding read
//   mem_ack        in   memory returns mem_rdata this cycle
//   mem_rdata      in   read data, valid when mem_ack
//   redirect_valid in   load a new PC (branch/jump taken)
//   redirect_addr  in   redirect target
//   instr_valid    out  instruction register holds a live instruction
//   instr_ready    in   decoder consumes the instruction this cycle
//   instruction    out  instruction register
//   pc_addr        out  address of the presented instruction
//   next_pc_addr   out  pc_addr + 1 (wraps)
//   stall_count    out  stall cycle counter (FETCH_STALL_COUNT_EN only)
//
// Build option:
//   FETCH_STALL_COUNT_EN - adds the saturating 32-bit stall_count output.
//
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit #(
    parameter int                           ADDRESS_BUS_WIDTH = 16,
    parameter int                           INSTRUCTION_WIDTH = 32,
    parameter logic [ADDRESS_BUS_WIDTH-1:0] RESET_VECTOR      = '0
) (
    input  logic                         clock,
    input  logic                         reset,
    output logic                         mem_req,
    output logic [ADDRESS_BUS_WIDTH-1:0] mem_addr,
    input  logic                         mem_ack,
    input  logic [INSTRUCTION_WIDTH-1:0] mem_rdata,
    input  logic                         redirect_valid,
    input  logic [ADDRESS_BUS_WIDTH-1:0] redirect_addr,
    output logic                         instr_valid,
    input  logic                         instr_ready,
    output logic [INSTRUCTION_WIDTH-1:0] instruction,
    output logic [ADDRESS_BUS_WIDTH-1:0] pc_addr,
    output logic [ADDRESS_BUS_WIDTH-1:0] next_pc_addr
`ifdef FETCH_STALL_COUNT_EN
    ,
    output logic [31:0]                  stall_count
`endif
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_REQ  = 2'd1;
    localparam logic [1:0] c_S_HOLD = 2'd2;

    localparam logic [ADDRESS_BUS_WIDTH-1:0] c_PC_STEP =
        {{(ADDRESS_BUS_WIDTH-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]                   r_state;
    logic [ADDRESS_BUS_WIDTH-1:0] r_fetch_pc;
    logic [ADDRESS_BUS_WIDTH-1:0] r_pc_addr;
    logic [INSTRUCTION_WIDTH-1:0] r_instruction;
    logic                         r_instr_valid;
    // Set when the PC was redirected while a read was already in flight:
    // the next mem_ack belongs to the stale address and must be dropped.
    logic                         r_redirect_pending;

    logic                         w_mem_req;

    // The request is a pure function of state, so after reset (S_IDLE) it is
    // low and any late acknowledge from an abandoned transaction is ignored.
    assign w_mem_req = (r_state == c_S_REQ);

    // ------------------------------------------------------------------------
    // Fetch control
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state            <= c_S_IDLE;
            r_fetch_pc         <= RESET_VECTOR;
            r_pc_addr          <= RESET_VECTOR;
            r_instruction      <= '0;
            r_instr_valid      <= 1'b0;
            r_redirect_pending <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (redirect_valid) begin
                        r_fetch_pc <= redirect_addr;
                    end
                    r_state <= c_S_REQ;
                end

                c_S_REQ: begin
                    if (redirect_valid) begin
                        // New target replaces the address on the bus. If the
                        // ack arrives in this same cycle its data belongs to
                        // the old address and is simply not captured; the
                        // next request already targets redirect_addr.
                        r_fetch_pc         <= redirect_addr;
                        r_redirect_pending <= ~mem_ack;
                    end else if (mem_ack) begin
                        if (r_redirect_pending) begin
                            // Stale data for the pre-redirect address.
                            r_redirect_pending <= 1'b0;
                        end else begin
                            r_instruction <= mem_rdata;
                            r_pc_addr     <= r_fetch_pc;
                            r_fetch_pc    <= r_fetch_pc + c_PC_STEP;
                            r_instr_valid <= 1'b1;
                            r_state       <= c_S_HOLD;
                        end
                    end
                end

                c_S_HOLD: begin
                    if (redirect_valid) begin
                        // The branch itself was consumed earlier; whatever is
                        // held now is on the wrong path, so it is dropped even
                        // if the decoder is ready this cycle.
                        r_instr_valid <= 1'b0;
                        r_fetch_pc    <= redirect_addr;
                        r_state       <= c_S_REQ;
                    end else if (instr_ready) begin
                        r_instr_valid <= 1'b0;
                        r_state       <= c_S_REQ;
                    end
                end

                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign mem_req      = w_mem_req;
    assign mem_addr     = r_fetch_pc;
    assign instr_valid  = r_instr_valid;
    assign instruction  = r_instruction;
    assign pc_addr      = r_pc_addr;
    assign next_pc_addr = r_pc_addr + c_PC_STEP;

`ifdef FETCH_STALL_COUNT_EN
    // ------------------------------------------------------------------------
    // Stall counter: cycles spent waiting on memory or on the decoder.
    // ------------------------------------------------------------------------
    logic [31:0] r_stall_count;
    logic        w_stall_cycle;

    assign w_stall_cycle = (w_mem_req && !mem_ack) ||
                           (r_instr_valid && !instr_ready);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_stall_count <= 32'd0;
        end else if (w_stall_cycle && (r_stall_count != 32'hFFFF_FFFF)) begin
            r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign stall_count = r_stall_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch_unit
// Description : Directed self-checking bench for instruction_fetch_unit.
//               A memory responder with a programmable number of wait states
//               returns {16'hC0DE, address} for every read.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;

    localparam int AW = 16;
    localparam int IW = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack = 1'b0;
    logic [IW-1:0] mem_rdata = '0;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_addr = '0;
    logic          instr_valid;
    logic          instr_ready = 1'b0;
    logic [IW-1:0] instruction;
    logic [AW-1:0] pc_addr;
    logic [AW-1:0] next_pc_addr;
`ifdef FETCH_STALL_COUNT_EN
    logic [31:0]   stall_count;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    int wait_states = 0;
    int wait_cnt    = 0;

    instruction_fetch_unit #(
        .ADDRESS_BUS_WIDTH (AW),
        .INSTRUCTION_WIDTH (IW),
        .RESET_VECTOR      (16'h0010)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instruction    (instruction),
        .pc_addr        (pc_addr),
        .next_pc_addr   (next_pc_addr)
`ifdef FETCH_STALL_COUNT_EN
        ,
        .stall_count    (stall_count)
`endif
    );

    always #5 clock = ~clock;

    function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
        return {16'hC0DE, a};
    endfunction

    // Memory: acknowledges after wait_states full cycles of mem_req.
    always @(negedge clock) begin
        if (mem_req === 1'b1) begin
            if (wait_cnt >= wait_states) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_word(mem_addr);
                wait_cnt  = 0;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = '0;
                wait_cnt  = wait_cnt + 1;
            end
        end else begin
            mem_ack   = 1'b0;
            mem_rdata = '0;
            wait_cnt  = 0;
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic wait_for_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (mem_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_for_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (instr_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
        n_cmp++; if (mem_addr !== 16'h0010) begin n_fail++; $display("FAIL reset_mem_addr: got %h expected 0010", mem_addr); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_instr_valid: got %b expected 0", instr_valid); end
        n_cmp++; if (instruction !== 32'h0) begin n_fail++; $display("FAIL reset_instruction: got %h expected 00000000", instruction); end
        n_cmp++; if (pc_addr !== 16'h0010) begin n_fail++; $display("FAIL reset_pc_addr: got %h expected 0010", pc_addr); end
        n_cmp++; if (next_pc_addr !== 16'h0011) begin n_fail++; $display("FAIL reset_next_pc: got %h expected 0011", next_pc_addr); end
`ifdef FETCH_STALL_COUNT_EN
        n_cmp++; if (stall_count !== 32'd0) begin n_fail++; $display("FAIL reset_stall_count: got %0d expected 0", stall_count); end
`endif
        wait_states = 0;
        instr_ready = 1'b1;
        reset       = 1'b0;
    endtask

    // Zero-wait memory, always-ready decoder: 0x10, 0x11, 0x12.
    task automatic test_sequential;
        bit            ok;
        logic [AW-1:0] exp;
        for (int k = 0; k < 3; k++) begin
            exp = AW'(16'h0010 + k);
            wait_for_req(ok);
            n_cmp++; if (!ok) begin n_fail++; $display("FAIL seq_req_timeout: got no mem_req expected mem_req for %h", exp); end
            n_cmp++; if (mem_addr !== exp) begin n_fail++; $display("FAIL seq_mem_addr: got %h expected %h", mem_addr, exp); end
            wait_for_valid(ok);
            n_cmp++; if (!ok) begin n_fail++; $display("FAIL seq_valid_timeout: got no instr_valid expected valid for %h", exp); end
            n_cmp++; if (instruction !== mem_word(exp)) begin n_fail++; $display("FAIL seq_instruction: got %h expected %h", instruction, mem_word(exp)); end
            n_cmp++; if (pc_addr !== exp) begin n_fail++; $display("FAIL seq_pc_addr: got %h expected %h", pc_addr, exp); end
            n_cmp++; if (next_pc_addr !== AW'(exp + 16'h1)) begin n_fail++; $display("FAIL seq_next_pc: got %h expected %h", next_pc_addr, AW'(exp + 16'h1)); end
            if (k == 2) instr_ready = 1'b0;
        end
    endtask

    // Decoder stalls for 5 cycles while 0x12 is held.
    task automatic test_hold;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_cmp++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid: got %b expected 1", instr_valid); end
            n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL hold_mem_req: got %b expected 0", mem_req); end
            n_cmp++; if (instruction !== mem_word(16'h0012)) begin n_fail++; $display("FAIL hold_instruction: got %h expected %h", instruction, mem_word(16'h0012)); end
            n_cmp++; if (pc_addr !== 16'h0012) begin n_fail++; $display("FAIL hold_pc_addr: got %h expected 0012", pc_addr); end
        end
    endtask

    // Three wait states: request held 4 cycles, valid 1 cycle after ack.
    task automatic test_wait_states;
        wait_states = 3;
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c != 0) tick();
            n_cmp++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL ws_mem_req: cycle %0d got %b expected 1", c, mem_req); end
            n_cmp++; if (mem_addr !== 16'h0013) begin n_fail++; $display("FAIL ws_mem_addr: cycle %0d got %h expected 0013", c, mem_addr); end
            n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL ws_early_valid: cycle %0d got %b expected 0", c, instr_valid); end
        end
        tick();
        n_cmp++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL ws_valid_latency: got %b expected 1", instr_valid); end
        n_cmp++; if (pc_addr !== 16'h0013) begin n_fail++; $display("FAIL ws_pc_addr: got %h expected 0013", pc_addr); end
        n_cmp++; if (instruction !== mem_word(16'h0013)) begin n_fail++; $display("FAIL ws_instruction: got %h expected %h", instruction, mem_word(16'h0013)); end
    endtask

    // Redirect to 0x0100 while the read of 0x0020 is waiting on its ack.
    task automatic test_redirect_req;
        bit ok;
        redirect_valid = 1'b1;
        redirect_addr  = 16'h0020;
        tick();
        redirect_valid = 1'b0;
        n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rq_hold_drop: got %b expected 0", instr_valid); end
        n_cmp++; if (mem_addr !== 16'h0020) begin n_fail++; $display("FAIL rq_first_addr: got %h expected 0020", mem_addr); end
        tick();
        redirect_valid = 1'b1;
        redirect_addr  = 16'h0100;
        tick();
        redirect_valid = 1'b0;
        n_cmp++; if (mem_addr !== 16'h0100) begin n_fail++; $display("FAIL rq_redirect_addr: got %h expected 0100", mem_addr); end
        tick();
        tick();
        // The stale ack has just been taken; nothing may be presented.
        n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rq_discard: got %b expected 0", instr_valid); end
        n_cmp++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rq_refetch_req: got %b expected 1", mem_req); end
        wait_for_valid(ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL rq_valid_timeout: got no instr_valid expected valid for 0100"); end
        n_cmp++; if (pc_addr !== 16'h0100) begin n_fail++; $display("FAIL rq_pc_addr: got %h expected 0100", pc_addr); end
        n_cmp++; if (instruction !== mem_word(16'h0100)) begin n_fail++; $display("FAIL rq_instruction: got %h expected %h", instruction, mem_word(16'h0100)); end
    endtask

    // Redirect in S_HOLD with instr_ready in the same cycle.
    task automatic test_redirect_hold;
        wait_states    = 0;
        redirect_valid = 1'b1;
        redirect_addr  = 16'h0200;
        instr_ready    = 1'b1;
        tick();
        redirect_valid = 1'b0;
        n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rh_valid_drop: got %b expected 0", instr_valid); end
        n_cmp++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rh_mem_req: got %b expected 1", mem_req); end
        n_cmp++; if (mem_addr !== 16'h0200) begin n_fail++; $display("FAIL rh_mem_addr: got %h expected 0200", mem_addr); end
        tick();
        n_cmp++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL rh_valid: got %b expected 1", instr_valid); end
        n_cmp++; if (pc_addr !== 16'h0200) begin n_fail++; $display("FAIL rh_pc_addr: got %h expected 0200", pc_addr); end
        n_cmp++; if (instruction !== mem_word(16'h0200)) begin n_fail++; $display("FAIL rh_instruction: got %h expected %h", instruction, mem_word(16'h0200)); end
    endtask

    // PC wrap from 0xFFFF to 0x0000, with 3 wait states per fetch.
    task automatic test_wrap;
        bit ok;
`ifdef FETCH_STALL_COUNT_EN
        logic [31:0] s0;
`endif
        wait_states    = 3;
        redirect_valid = 1'b1;
        redirect_addr  = 16'hFFFF;
        tick();
        redirect_valid = 1'b0;
        n_cmp++; if (mem_addr !== 16'hFFFF) begin n_fail++; $display("FAIL wr_mem_addr_top: got %h expected ffff", mem_addr); end
        wait_for_valid(ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL wr_valid_timeout: got no instr_valid expected valid for ffff"); end
        n_cmp++; if (pc_addr !== 16'hFFFF) begin n_fail++; $display("FAIL wr_pc_top: got %h expected ffff", pc_addr); end
        n_cmp++; if (next_pc_addr !== 16'h0000) begin n_fail++; $display("FAIL wr_next_pc: got %h expected 0000", next_pc_addr); end
`ifdef FETCH_STALL_COUNT_EN
        s0 = stall_count;
`endif
        wait_for_req(ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL wr_req_timeout: got no mem_req expected mem_req for 0000"); end
        n_cmp++; if (mem_addr !== 16'h0000) begin n_fail++; $display("FAIL wr_mem_addr_wrap: got %h expected 0000", mem_addr); end
        wait_for_valid(ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL wr_valid2_timeout: got no instr_valid expected valid for 0000"); end
        n_cmp++; if (pc_addr !== 16'h0000) begin n_fail++; $display("FAIL wr_pc_wrap: got %h expected 0000", pc_addr); end
`ifdef FETCH_STALL_COUNT_EN
        n_cmp++; if (stall_count - s0 !== 32'd3) begin n_fail++; $display("FAIL wr_stall_delta: got %0d expected 3", stall_count - s0); end
`endif
    endtask

    // Reset while a read is outstanding abandons it.
    task automatic test_reset_mid;
        tick();
        tick();
        reset = 1'b1;
        tick();
        n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rm_mem_req: got %b expected 0", mem_req); end
        n_cmp++; if (mem_addr !== 16'h0010) begin n_fail++; $display("FAIL rm_mem_addr: got %h expected 0010", mem_addr); end
        n_cmp++; if (pc_addr !== 16'h0010) begin n_fail++; $display("FAIL rm_pc_addr: got %h expected 0010", pc_addr); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rm_valid: got %b expected 0", instr_valid); end
`ifdef FETCH_STALL_COUNT_EN
        n_cmp++; if (stall_count !== 32'd0) begin n_fail++; $display("FAIL rm_stall_count: got %0d expected 0", stall_count); end
`endif
        reset = 1'b0;
        tick();
        n_cmp++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rm_restart_req: got %b expected 1", mem_req); end
        n_cmp++; if (mem_addr !== 16'h0010) begin n_fail++; $display("FAIL rm_restart_addr: got %h expected 0010", mem_addr); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_hold();
        test_wait_states();
        test_redirect_req();
        test_redirect_hold();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch stage directly upstream of decode_instruction in the multi-cycle computer; owns the program counter.
- Issues word reads to instruction memory over a req/ack handshake, latches the returned word into an instruction register and presents it to the decoder with a valid/ready handshake.
- Accepts redirects (branch/jump targets) from execute; supplies pc_addr/next_pc_addr to the datapath.

Parameters:
ADDRESS_BUS_WIDTH, 16, PC/memory address width
INSTRUCTION_WIDTH, 32, instruction word width
RESET_VECTOR, 0, PC value loaded on reset

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
mem_req  output  1  instruction memory read request
mem_addr  output  ADDRESS_BUS_WIDTH  read address, word-addressed
mem_ack  input  1  memory returns mem_rdata this cycle
mem_rdata  input  INSTRUCTION_WIDTH  read data, valid when mem_ack
redirect_valid  input  1  load new PC (branch/jump taken)
redirect_addr  input  ADDRESS_BUS_WIDTH  redirect target
instr_valid  output  1  instruction register holds a live instruction
instr_ready  input  1  decoder consumes instruction this cycle
instruction  output  INSTRUCTION_WIDTH  instruction register to decoder
pc_addr  output  ADDRESS_BUS_WIDTH  address of presented instruction
next_pc_addr  output  ADDRESS_BUS_WIDTH  pc_addr + 1, modulo 2^ADDRESS_BUS_WIDTH

Behaviour:
- Interface: single clock `clock`; `reset` synchronous, active-high; takes priority over every other input.
- Reset values: state=S_IDLE, fetch_pc=RESET_VECTOR, mem_req=0, mem_addr=RESET_VECTOR, instr_valid=0, instruction=0, pc_addr=RESET_VECTOR, redirect_pending=0.
- States:
  - S_IDLE: one cycle after reset; -> S_REQ.
  - S_REQ: mem_req=1, mem_addr=fetch_pc. Hold both stable until mem_ack. On mem_ack with redirect_pending=0: instruction<=mem_rdata, pc_addr<=fetch_pc, fetch_pc<=fetch_pc+1, instr_valid<=1, -> S_HOLD. On mem_ack with redirect_pending=1: discard data, clear pending, stay in S_REQ (new address already in fetch_pc).
  - S_HOLD: mem_req=0, instr_valid=1. On instr_ready: instr_valid<=0, -> S_REQ.
- Latency: mem_ack in cycle N -> instr_valid=1 in N+1. Handshake accept in cycle M -> mem_req=1 in M+1. mem_ack is ignored when mem_req=0.
- Redirects:
  - In S_REQ: fetch_pc<=redirect_addr. redirect_pending<=1 unless mem_ack is asserted the same cycle; in that case the data is discarded and the next request targets redirect_addr.
  - In S_HOLD: instr_valid<=0, fetch_pc<=redirect_addr, -> S_REQ. The held instruction is dropped, whether or not instr_ready is also high (the branch instruction was consumed earlier).
  - Back-to-back redirects: last one wins.
  - In S_IDLE: fetch_pc<=redirect_addr.
- Wrap-around: fetch_pc=2^AW-1 increments to 0; no flag.
- next_pc_addr is combinational from pc_addr.
- Reset mid-transaction: outstanding request is abandoned; a late mem_ack after reset is ignored because mem_req=0 in S_IDLE.

Optional Feature:
- Macro: FETCH_STALL_COUNT_EN.
- Defined:
  - Adds output stall_count[31:0], reset 0.
  - Increments each cycle with mem_req=1 && mem_ack=0, or instr_valid=1 && instr_ready=0.
  - Saturates at 32'hFFFFFFFF.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset with RESET_VECTOR=16'h0010, memory acks after 0 wait cycles, instr_ready=1 -> mem_addr sequence 0x0010,0x0011,0x0012; instruction/pc_addr pairs match; next_pc_addr=pc_addr+1.
- Memory with 3 wait states -> mem_req and mem_addr stable for 4 cycles; instr_valid rises exactly 1 cycle after mem_ack.
- Decoder holds instr_ready=0 for 5 cycles in S_HOLD -> instruction, pc_addr and instr_valid stable; no mem_req asserted.
- redirect to 0x0100 while a request to 0x0020 is waiting on ack -> returned word discarded, instr_valid stays 0, next mem_addr=0x0100.
- redirect to 0x0200 in S_HOLD with instr_ready=1 in the same cycle -> instr_valid=0 next cycle; next fetch at 0x0200; held instruction never accepted twice.
- fetch_pc=16'hFFFF -> following fetch at 0x0000; with FETCH_STALL_COUNT_EN, 3 wait states per fetch -> stall_count +3 per instruction.
